// File: rtl/ldst_seq_pkg.sv
// Shared types for the Mini-SRC load/store sequencer: state encoding, opcode
// defaults and the control word decoded from the state register.
package ldst_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_T0    = 4'd1,
      ST_T1    = 4'd2,
      ST_T2    = 4'd3,
      ST_T3    = 4'd4,
      ST_T4    = 4'd5,
      ST_T5    = 4'd6,
      ST_T6    = 4'd7,
      ST_T7    = 4'd8,
      ST_DONE  = 4'd9,
      ST_FAULT = 4'd10
   } state_e;

   // Instruction class captured in T3; steers the T5..T7 schedule.
   typedef enum logic [1:0] {
      K_LD  = 2'd0,
      K_LDI = 2'd1,
      K_ST  = 2'd2
   } op_kind_e;

   localparam logic [4:0] OPC_LD_DEF  = 5'b00000;
   localparam logic [4:0] OPC_LDI_DEF = 5'b00001;
   localparam logic [4:0] OPC_ST_DEF  = 5'b00010;
   localparam logic [4:0] ALU_ADD_DEF = 5'b00100;

   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic read;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic grb;
      logic ba_out;
      logic y_in;
      logic c_out;
      logic zhigh_in;
      logic zlow_in;
      logic zlow_out;
      logic gra;
      logic r_in;
      logic r_out;
      logic write;
      logic busy;
      logic done;
      logic err;
   } ctrl_word_t;

endpackage

// File: rtl/ldst_wait_timer.sv
// Saturating memory-stall counter; expired flags that the current low cycle
// is the WAIT_MAX-th consecutive one.
module ldst_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic Clock,
   input  logic Clear,
   input  logic clr,
   input  logic stall,
   output logic expired
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != CNT_W'(WAIT_MAX))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q >= CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/ldst_sequencer.sv
// Moore control-step sequencer for Mini-SRC ld/ldi/st with memory-ready stalls.
// Define LDST_SEQ_TIMEOUT_EN to fault a memory state after WAIT_MAX low cycles.
module ldst_sequencer
   import ldst_seq_pkg::*;
#(
   parameter int              OP_W     = 5,
   parameter logic [OP_W-1:0] OPC_LD   = OP_W'(OPC_LD_DEF),
   parameter logic [OP_W-1:0] OPC_LDI  = OP_W'(OPC_LDI_DEF),
   parameter logic [OP_W-1:0] OPC_ST   = OP_W'(OPC_ST_DEF),
   parameter logic [OP_W-1:0] ALU_ADD  = OP_W'(ALU_ADD_DEF),
   parameter int              WAIT_MAX = 15
) (
   input  logic            Clock,
   input  logic            Clear,
   input  logic            start,
   input  logic [OP_W-1:0] ir_op,
   input  logic            mem_ready,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            PCout,
   output logic            MARin,
   output logic            IncPC,
   output logic            Read,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Grb,
   output logic            BAout,
   output logic            Yin,
   output logic            Cout,
   output logic            ZHighin,
   output logic            ZLowin,
   output logic            ZLowout,
   output logic            Gra,
   output logic            Rin,
   output logic            Rout,
   output logic            Write,
   output logic [OP_W-1:0] OP
);

   localparam logic [3:0] S_IDLE  = ST_IDLE;
   localparam logic [3:0] S_T0    = ST_T0;
   localparam logic [3:0] S_T1    = ST_T1;
   localparam logic [3:0] S_T2    = ST_T2;
   localparam logic [3:0] S_T3    = ST_T3;
   localparam logic [3:0] S_T4    = ST_T4;
   localparam logic [3:0] S_T5    = ST_T5;
   localparam logic [3:0] S_T6    = ST_T6;
   localparam logic [3:0] S_T7    = ST_T7;
   localparam logic [3:0] S_DONE  = ST_DONE;
   localparam logic [3:0] S_FAULT = ST_FAULT;

   if (WAIT_MAX < 1) begin : g_wait_max_invalid
      $error("ldst_sequencer: WAIT_MAX must be at least 1");
   end

   logic [3:0] state_q, state_d;
   op_kind_e   kind_q, kind_d;
   logic       supported;
   logic       mem_state;
   logic       timeout;
   ctrl_word_t cw;

   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      kind_d    = K_LD;
      supported = 1'b1;
      if (ir_op == OPC_LD) begin
         kind_d = K_LD;
      end else if (ir_op == OPC_LDI) begin
         kind_d = K_LDI;
      end else if (ir_op == OPC_ST) begin
         kind_d = K_ST;
      end else begin
         supported = 1'b0;
      end
   end

   assign mem_state = (state_q == S_T1)
                   || ((state_q == S_T6) && (kind_q == K_LD))
                   || ((state_q == S_T7) && (kind_q == K_ST));

`ifdef LDST_SEQ_TIMEOUT_EN
   logic expired;

   // Counter is held clear outside memory states, so each entry starts at zero.
   ldst_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .Clock   (Clock),
      .Clear   (Clear),
      .clr     (!mem_state),
      .stall   (mem_state && !mem_ready),
      .expired (expired)
   );

   assign timeout = expired && !mem_ready;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1: begin
            if (mem_ready)    state_d = S_T2;
            else if (timeout) state_d = S_FAULT;
         end
         S_T2:    state_d = S_T3;
         S_T3:    state_d = supported ? S_T4 : S_FAULT;
         S_T4:    state_d = S_T5;
         S_T5:    state_d = (kind_q == K_LDI) ? S_DONE : S_T6;
         S_T6: begin
            if (kind_q != K_LD || mem_ready) state_d = S_T7;
            else if (timeout)                state_d = S_FAULT;
         end
         S_T7: begin
            if (kind_q != K_ST || mem_ready) state_d = S_DONE;
            else if (timeout)                state_d = S_FAULT;
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q <= S_IDLE;
         kind_q  <= K_LD;
      end else begin
         state_q <= state_d;
         if (state_q == S_T3) kind_q <= kind_d;
      end
   end

   // Outputs depend only on registered state, so Clear zeroes them at once.
   always_comb begin
      cw = '0;
      OP = '0;
      cw.busy = (state_q != S_IDLE);
      case (state_q)
         S_T0: begin
            cw.pc_out = 1'b1;
            cw.mar_in = 1'b1;
            cw.inc_pc = 1'b1;
         end
         S_T1: begin
            cw.read   = 1'b1;
            cw.mdr_in = 1'b1;
         end
         S_T2: begin
            cw.mdr_out = 1'b1;
            cw.ir_in   = 1'b1;
         end
         S_T3: begin
            cw.grb    = 1'b1;
            cw.ba_out = 1'b1;
            cw.y_in   = 1'b1;
         end
         S_T4: begin
            cw.c_out    = 1'b1;
            cw.zhigh_in = 1'b1;
            cw.zlow_in  = 1'b1;
            OP          = ALU_ADD;
         end
         S_T5: begin
            cw.zlow_out = 1'b1;
            if (kind_q == K_LDI) begin
               cw.gra  = 1'b1;
               cw.r_in = 1'b1;
            end else begin
               cw.mar_in = 1'b1;
            end
         end
         S_T6: begin
            cw.mdr_in = 1'b1;
            if (kind_q == K_ST) begin
               cw.gra   = 1'b1;
               cw.r_out = 1'b1;
            end else begin
               cw.read = 1'b1;
            end
         end
         S_T7: begin
            cw.mdr_out = 1'b1;
            if (kind_q == K_ST) begin
               cw.write = 1'b1;
            end else begin
               cw.gra  = 1'b1;
               cw.r_in = 1'b1;
            end
         end
         S_DONE:  cw.done = 1'b1;
         S_FAULT: begin
            cw.done = 1'b1;
            cw.err  = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy    = cw.busy;
   assign done    = cw.done;
   assign err     = cw.err;
   assign PCout   = cw.pc_out;
   assign MARin   = cw.mar_in;
   assign IncPC   = cw.inc_pc;
   assign Read    = cw.read;
   assign MDRin   = cw.mdr_in;
   assign MDRout  = cw.mdr_out;
   assign IRin    = cw.ir_in;
   assign Grb     = cw.grb;
   assign BAout   = cw.ba_out;
   assign Yin     = cw.y_in;
   assign Cout    = cw.c_out;
   assign ZHighin = cw.zhigh_in;
   assign ZLowin  = cw.zlow_in;
   assign ZLowout = cw.zlow_out;
   assign Gra     = cw.gra;
   assign Rin     = cw.r_in;
   assign Rout    = cw.r_out;
   assign Write   = cw.write;

endmodule

// File: doc/ldst_sequencer.md
# ldst_sequencer

Parametrised load/store control-step sequencer for the Mini-SRC datapath. It replaces hand-scheduled T-state control with a Moore FSM that fetches an instruction, decodes `ld`/`ldi`/`st`, and drives the datapath control strobes step by step. Unlike a fixed T0–T7 schedule, it stalls on a memory-ready handshake and optionally times out on a hung memory. It sits between the top-level control unit and `datapath`.

## Interface
Parameters:
- `OP_W`, 5: width of the opcode input and the ALU `OP` output.
- `OPC_LD`, 5'b00000: `ld` opcode.
- `OPC_LDI`, 5'b00001: `ldi` opcode.
- `OPC_ST`, 5'b00010: `st` opcode.
- `ALU_ADD`, 5'b00100: ALU add code driven on `OP` in T4.
- `WAIT_MAX`, 15: number of consecutive memory-stall cycles before a fault (≥1).

Ports:
- `Clock`  in  1  single clock, rising edge.
- `Clear`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one instruction; sampled only in IDLE.
- `ir_op`  in  OP_W  IR[31:27]; sampled in T3.
- `mem_ready`  in  1  memory has completed the current Read/Write.
- `busy`, `done`, `err`  out  1  status.
- Strobes, each `out 1`: `PCout`, `MARin`, `IncPC`, `Read`, `MDRin`, `MDRout`, `IRin`, `Grb`, `BAout`, `Yin`, `Cout`, `ZHighin`, `ZLowin`, `ZLowout`, `Gra`, `Rin`, `Rout`, `Write`.
- `OP`  out  OP_W  ALU operation.

## Operation
- States: IDLE, T0–T7, DONE, FAULT.
- Outputs are decoded from the state register only, with no input-to-output combinational path. Every output is 0 in IDLE and while `Clear`=0.
- T0: PCout, MARin, IncPC.
- T1: Read, MDRin. Hold until `mem_ready`.
- T2: MDRout, IRin.
- T3: Grb, BAout, Yin. Latch `ir_op`.
  - Unsupported opcode → FAULT.
- T4: Cout, ZHighin, ZLowin, OP=ALU_ADD. `OP` is 0 in all other states.
- T5:
  - `ldi`: ZLowout, Gra, Rin → DONE.
  - `ld`/`st`: ZLowout, MARin → T6.
- T6:
  - `ld`: Read, MDRin. Hold until `mem_ready`.
  - `st`: Gra, Rout, MDRin.
- T7:
  - `ld`: MDRout, Gra, Rin.
  - `st`: MDRout, Write. Hold until `mem_ready`.
- DONE: `done`=1 for one cycle → IDLE.
- FAULT: `err`=1 and `done`=1 for one cycle. Read and Write are 0. → IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored and not queued.
- `Clear` low mid-instruction: state→IDLE and all outputs→0 immediately. In-flight Read/Write is abandoned.

## Timing
- `start`=1 at edge k in IDLE puts T0 in cycle k+1.
- Each non-memory T-state lasts exactly one cycle.
- A memory state (T1; T6 for `ld`; T7 for `st`) exits on the first edge at which `mem_ready`=1. With no stall it lasts one cycle.
- Zero-stall latency from the `start` edge to `done` high:
  - `ld`/`st`: 9 cycles.
  - `ldi`: 7 cycles.
- Each stall cycle adds one cycle.
- Wait counter: width $clog2(WAIT_MAX+1). It clears on entry to each memory state and saturates at WAIT_MAX.
- `mem_ready` high in a cycle is ignored outside memory states.

## Configuration
- `LDST_SEQ_TIMEOUT_EN` defined:
  - A memory state with `mem_ready`=0 for WAIT_MAX consecutive cycles moves to FAULT at the edge ending the WAIT_MAX-th low cycle.
  - If `mem_ready` rises in that same cycle, ready wins and there is no fault.
- Not defined: no counter is built, memory states wait indefinitely, and `err` is asserted only for an unsupported opcode.

## Structure
- Package `ldst_seq_pkg` holds:
  - the state enum;
  - default opcode and ALU-code localparams;
  - a control-word struct bundling the strobes, used for the state→output decode.
- Sub-module `ldst_wait_timer` holds the saturating stall counter and its `expired` output. It is instantiated only under `LDST_SEQ_TIMEOUT_EN`.

## Test plan
- Reset:
  - Drive `Clear`=0 mid-T4 of an `st` → all outputs 0 in the same cycle and `busy`=0.
  - Release `Clear` → stays in IDLE.
- `st`, `ir_op`=5'b00010, `mem_ready`=1 → T0–T7 in order, `Write` high only in T7, `OP`=5'b00100 only in T4, and `done` 9 cycles after `start`.
- `ld` with `mem_ready` low for 3 cycles in T6 → `Read`/`MDRin` held 4 cycles and `done` at cycle 12. In T7, `Rin` and `Gra` are high together with MDRout.
- `ldi` (5'b00001) → ZLowout+Gra+Rin in T5, `done` at cycle 7, and no Read after T1.
- Unsupported opcode 5'b01111 → FAULT in the cycle after T3, `err`=`done`=1 for one cycle, then IDLE. A `start` pulse during busy is ignored.
- With `LDST_SEQ_TIMEOUT_EN`, WAIT_MAX=15, `mem_ready` stuck low in T1 → FAULT after 15 stall cycles. Repeat with `mem_ready` rising on the 15th cycle → no fault, normal completion.
